// File: rtl/reg_file_wr_arbiter.sv
// Write-port arbiter for a 2-entry register file with two requesters.
// Each requester issues a plain WRITE or an RMW ADD. A 3-state FSM
// (IDLE/READ/WRITE) handles one operation at a time, so every RMW sees
// all earlier writes. Requesters are granted round-robin.

// Per-requester handshake lane: ready while its grant is being accepted,
// done while its latched write is on the register file port.
module reg_file_wr_arbiter_lane #(
  parameter int ID = 0
) (
  input  logic acc,
  input  logic gnt_id,
  input  logic wr_cyc,
  input  logic id_q,
  output logic ready,
  output logic done
);
  assign ready = acc && (int'(gnt_id) == ID);
  assign done  = wr_cyc && (int'(id_q) == ID);
endmodule

module reg_file_wr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid_in,
  input  logic [1:0]            req_op_in,
  input  logic [2*ADDR_W-1:0]   req_addr_in,
  input  logic [2*DATA_W-1:0]   req_data_in,
  output logic [1:0]            req_ready_out,
  output logic [1:0]            done_out,
  output logic                  busy_out,
  input  logic [DATA_W-1:0]     rf_a_in,
  output logic [ADDR_W-1:0]     rf_raddr_out,
  output logic                  rf_wen_out,
  output logic [ADDR_W-1:0]     rf_waddr_out,
  output logic [DATA_W-1:0]     rf_c_out
);

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  // Latched request; cleared on reset
  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              id;
  } req_t;

  state_t            state, state_nxt;
  req_t              req_q;
  logic              prio;
  logic [DATA_W-1:0] rd_q;

  logic              gnt_id;
  logic              acc;
  logic              wr_cyc;
  req_t              req_sel;

  // Grant: priority pointer breaks ties, a lone requester wins outright
  always_comb begin
    gnt_id = 1'b0;
    if (&req_valid_in)        gnt_id = prio;
    else if (req_valid_in[1]) gnt_id = 1'b1;
  end

  // A ready bit is only raised toward a valid requester, so ready implies transfer
  assign acc    = (state == IDLE) && (|req_valid_in);
  assign wr_cyc = (state == WRITE);

  assign req_sel.op   = req_op_in[gnt_id];
  assign req_sel.addr = req_addr_in[gnt_id*ADDR_W +: ADDR_W];
  assign req_sel.data = req_data_in[gnt_id*DATA_W +: DATA_W];
  assign req_sel.id   = gnt_id;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = req_sel.op ? READ : WRITE;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, round-robin pointer and read capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q <= '0;
      prio  <= 1'b0;
      rd_q  <= '0;
    end else begin
      if (acc) begin
        req_q <= req_sel;
        prio  <= ~gnt_id;
      end
      if (state == READ) rd_q <= rf_a_in;
    end
  end

  // Per-requester ready/done lanes
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    reg_file_wr_arbiter_lane #(.ID(i)) u_lane (
      .acc    (acc),
      .gnt_id (gnt_id),
      .wr_cyc (wr_cyc),
      .id_q   (req_q.id),
      .ready  (req_ready_out[i]),
      .done   (done_out[i])
    );
  end

  // Register file port outputs; write data is forced to zero outside WRITE
  always_comb begin
    rf_wen_out   = 1'b0;
    rf_waddr_out = '0;
    rf_c_out     = '0;
    if (wr_cyc) begin
      rf_wen_out   = 1'b1;
      rf_waddr_out = req_q.addr;
      rf_c_out     = req_q.op ? (rd_q + req_q.data) : req_q.data;
    end
  end

  assign rf_raddr_out = req_q.addr;
  assign busy_out     = (state != IDLE);

endmodule

// File: doc/reg_file_wr_arbiter.md
Name: reg_file_wr_arbiter

Overview:
- Shares the single write port of the 2-entry x 16-bit register file (1 read port, 1 write port) between two requesters.
- Each requester issues either a plain WRITE or a read-modify-write ADD (RMW: reg := reg + operand).
- A 3-state FSM serialises operations, so an RMW always sees every earlier write. Requesters are picked round-robin.
- The block sits directly in front of the register file and drives its write enable, write address, write data and read address.

Parameters:
- DATA_W, 16, data width of the register file and of request operands.
- ADDR_W, 1, register address width (2 entries).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid_in  input  2  bit i: requester i has a request pending.
- req_op_in  input  2  bit i: requester i operation, 0 = WRITE, 1 = RMW ADD.
- req_addr_in  input  2*ADDR_W  requester i target address, in slice [i*ADDR_W +: ADDR_W].
- req_data_in  input  2*DATA_W  requester i data/operand, in slice [i*DATA_W +: DATA_W].
- req_ready_out  output  2  bit i: request i accepted this cycle.
- done_out  output  2  bit i: one-cycle pulse when requester i's write is issued.
- busy_out  output  1  high when the FSM is not in IDLE.
- rf_a_in  input  DATA_W  register file read data (combinational from rf_raddr_out).
- rf_raddr_out  output  ADDR_W  register file read address.
- rf_wen_out  output  1  register file write enable.
- rf_waddr_out  output  ADDR_W  register file write address.
- rf_c_out  output  DATA_W  register file write data.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, prio = 0.
  - Latched op, addr, data, id and read-capture register rd_q all cleared to 0.
  - All outputs 0.
- Reset during READ or WRITE abandons the operation. No write is issued and no done pulse is generated.
- FSM states: IDLE, READ, WRITE.
- IDLE:
  - Grant selection: if both valid bits are set, grant requester prio; if only one is set, grant that one.
  - req_ready_out[grant] is combinationally high in the same cycle. At most one ready bit is ever high.
  - Transfer happens when valid and ready are both high. On transfer:
    - latch op, addr, data and id;
    - prio := ~grant;
    - next state = READ if op = 1, else WRITE.
  - If no request is valid, stay in IDLE; prio is unchanged.
- READ: rd_q := rf_a_in, next state = WRITE.
- WRITE:
  - Combinational outputs: rf_wen_out = 1, rf_waddr_out = latched addr.
  - rf_c_out = latched data for WRITE, or (rd_q + latched data) mod 2^DATA_W for RMW; carry is discarded.
  - done_out[id] = 1; next state = IDLE.
- rf_raddr_out = latched addr in all states, held between operations.
- Outside WRITE: rf_wen_out = 0 and rf_c_out = 0.
- busy_out = (state != IDLE). req_ready_out = 0 whenever busy_out = 1.
- Latency, with acceptance in cycle N:
  - WRITE: rf_wen_out high in cycle N+1.
  - RMW: read in N+1, rf_wen_out high in N+2.
  - The register file is updated at the end of the write cycle.
- Throughput: at least one IDLE cycle between operations; there is no back-to-back issue.
- Requesters must hold valid, op, addr and data stable until ready is seen. Dropping valid before ready is legal, and that request is simply not accepted.
- A request sampled while busy is ignored until the FSM returns to IDLE.

Test Plan:
- Reset, then requester 0 issues WRITE addr=1 data=0x1234 -> ready[0] in the accept cycle, rf_wen_out=1 with waddr=1 and c=0x1234 in the next cycle, done_out=2'b01; a read of reg1 then returns 0x1234.
- Both requesters valid and held, each doing WRITE, repeated 4 times -> grants alternate 0,1,0,1 starting from 0; done pulses alternate.
- reg0 = 0xFFFE, then requester 1 issues RMW addr=0 data=0x0003 -> rf_raddr_out=0 in the READ cycle, rf_c_out=0x0001 in the WRITE cycle (carry dropped), done_out=2'b10.
- Requester 0 issues WRITE reg1=5 while requester 1 holds RMW reg1 +7 -> requester 1 is accepted only after IDLE; final reg1 = 12.
- Reset asserted during the READ cycle of an RMW -> rf_wen_out stays 0, no done pulse, state returns to IDLE, prio = 0.
- Requester 1 asserts valid for one cycle while the FSM is busy, then drops it -> never accepted, no write to the register file.
